// File: rtl/dual_rail_mem_responder.sv
// Dual-rail (t/f) memory responder: synchronizes an address wavefront,
// reads a small register file and returns the word as a dual-rail data
// wavefront under a four-phase NULL/DATA handshake.
module dual_rail_mem_responder #(
  parameter int AW          = 4,
  parameter int DW          = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] A_t,
  input  logic [AW-1:0] A_f,
  input  logic          Ki,
  output logic          Ko,
  output logic [DW-1:0] D_t,
  output logic [DW-1:0] D_f,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic          err,
  input  logic          err_clr
);

  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    S_WAIT_DATA,
    S_READ,
    S_DATA,
    S_NULL
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0][AW-1:0] a_t_sync;
  logic [SYNC_STAGES-1:0][AW-1:0] a_f_sync;
  logic [SYNC_STAGES-1:0]         ki_sync;

  logic [AW-1:0] sA_t, sA_f;
  logic          sKi;

  logic          illegal, complete_data, complete_null;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] addr_q, addr_d;
  logic          ko_q, ko_d;
  logic [DW-1:0] d_t_q, d_t_d;
  logic [DW-1:0] d_f_q, d_f_d;
  logic          err_q;

  // Synchronizer chains for both address rails and the consumer acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_t_sync <= '0;
      a_f_sync <= '0;
      ki_sync  <= '0;
    end else begin
      a_t_sync <= {a_t_sync[SYNC_STAGES-2:0], A_t};
      a_f_sync <= {a_f_sync[SYNC_STAGES-2:0], A_f};
      ki_sync  <= {ki_sync[SYNC_STAGES-2:0], Ki};
    end
  end

  assign sA_t = a_t_sync[SYNC_STAGES-1];
  assign sA_f = a_f_sync[SYNC_STAGES-1];
  assign sKi  = ki_sync[SYNC_STAGES-1];

  // Wavefront classification on the synchronized rails
  always_comb begin
    illegal       = |(sA_t & sA_f);
    complete_data = &(sA_t ^ sA_f);
    complete_null = ~|(sA_t | sA_f);
  end

  // Register-file storage; single-rail load port writes in any state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  // Sticky illegal-code flag; a new illegal code beats a clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (illegal) begin
      err_q <= 1'b1;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end
  end

  // State, latched address and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT_DATA;
      addr_q  <= '0;
      ko_q    <= 1'b1;
      d_t_q   <= '0;
      d_f_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ko_q    <= ko_d;
      d_t_q   <= d_t_d;
      d_f_q   <= d_f_d;
    end
  end

  // Next-state and next-output decode. The D_t register doubles as the data
  // register: the word read in S_READ lands directly on the output rails, so
  // both rails and Ko switch on the same edge and D never shows a partial word.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ko_d    = ko_q;
    d_t_d   = d_t_q;
    d_f_d   = d_f_q;
    case (state_q)
      S_WAIT_DATA: begin
        ko_d  = 1'b1;
        d_t_d = '0;
        d_f_d = '0;
        if (complete_data && sKi && !illegal) begin
          addr_d  = sA_t;
          state_d = S_READ;
        end
      end
      S_READ: begin
        d_t_d   = mem[addr_q];
        d_f_d   = ~mem[addr_q];
        ko_d    = 1'b0;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (complete_null && !sKi && !illegal) begin
          d_t_d   = '0;
          d_f_d   = '0;
          ko_d    = 1'b1;
          state_d = S_NULL;
        end
      end
      S_NULL: begin
        ko_d  = 1'b1;
        d_t_d = '0;
        d_f_d = '0;
        if (sKi && !illegal) begin
          state_d = S_WAIT_DATA;
        end
      end
      default: begin
        state_d = S_WAIT_DATA;
        ko_d    = 1'b1;
        d_t_d   = '0;
        d_f_d   = '0;
      end
    endcase
  end

  assign Ko  = ko_q;
  assign D_t = d_t_q;
  assign D_f = d_f_q;
  assign err = err_q;

endmodule

// File: tb/tb_dual_rail_mem_responder.sv
// Scoreboard bench for dual_rail_mem_responder: stimulus pushes expected
// words with their due cycle; a negedge monitor pops and checks them.
module tb_dual_rail_mem_responder;

  localparam int AW   = 4;
  localparam int DW   = 4;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] A_t, A_f;
  logic          Ki, Ko;
  logic [DW-1:0] D_t, D_f;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          err, err_clr;

  dual_rail_mem_responder #(
    .AW(AW),
    .DW(DW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .A_t(A_t),
    .A_f(A_f),
    .Ki(Ki),
    .Ko(Ko),
    .D_t(D_t),
    .D_f(D_f),
    .load_en(load_en),
    .load_addr(load_addr),
    .load_data(load_data),
    .err(err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] word;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [DW-1:0] mon_inv;
  logic prev_data = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: legal-code check every cycle, scoreboard pop on each new DATA wavefront
  always @(negedge clk) begin
    if (rst) begin
      prev_data = 1'b0;
    end else begin
      tests++;
      if ((D_t & D_f) != 0 || !((D_t ^ D_f) == 4'hF || (D_t | D_f) == 0)) begin
        fails++;
        $display("FAIL d_code: got t=%b f=%b expected full NULL or full DATA", D_t, D_f);
      end
      if ((D_t ^ D_f) == 4'hF && !prev_data) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_data: got t=%b expected no DATA wavefront", D_t);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_inv = ~mon_e.word;
          chk("d_t", D_t, mon_e.word);
          chk("d_f", D_f, mon_inv);
          chk("ko_with_data", Ko, 0);
          chk("latency", cyc, mon_e.due);
        end
      end
      prev_data = ((D_t ^ D_f) == 4'hF);
    end
  end

  task automatic drive_addr(input logic [AW-1:0] a);
    A_t = a;
    A_f = ~a;
  endtask

  task automatic drive_null();
    A_t = '0;
    A_f = '0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] w);
    @(negedge clk);
    drive_addr(a);
    Ki = 1'b1;
    exp_q.push_back('{w, cyc + LAT});
  endtask

  task automatic wait_ko(input logic lvl, input string name);
    int n = 0;
    while (Ko !== lvl && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, Ko, lvl);
  endtask

  task automatic finish_txn();
    @(negedge clk);
    drive_null();
    Ki = 1'b0;
    repeat (2) @(negedge clk);
    chk("ko_hold_before_null", Ko, 0);
    @(negedge clk);
    chk("ko_rise", Ko, 1);
    chk("d_null", {D_t, D_f}, 0);
    Ki = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; Ki = 1'b1; err_clr = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    drive_null();
    #3;
    chk("reset_ko", Ko, 1);
    chk("reset_d", {D_t, D_f}, 0);
    chk("reset_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    load(4'd3, 4'hA);
    load(4'd5, 4'h6);
    load(4'd9, 4'hF);

    // Basic read of addr 3 and return to NULL
    issue(4'd3, 4'hA);
    wait_ko(1'b0, "ko_fall_a3");
    finish_txn();

    // Partial wavefront (bit 2 NULL) held, then completed
    @(negedge clk);
    A_t = 4'b0011; A_f = 4'b1000; Ki = 1'b1;
    repeat (10) @(negedge clk);
    chk("partial_ko", Ko, 1);
    chk("partial_d", {D_t, D_f}, 0);
    chk("partial_err", err, 0);
    A_f = 4'b1100;
    exp_q.push_back('{4'hA, cyc + LAT});
    wait_ko(1'b0, "ko_fall_partial");
    finish_txn();

    // Illegal code, clear, and set-wins-over-clear
    @(negedge clk);
    A_t = 4'b0010; A_f = 4'b0010;
    repeat (3) @(negedge clk);
    chk("err_set", err, 1);
    chk("illegal_ko", Ko, 1);
    chk("illegal_d", {D_t, D_f}, 0);
    drive_null();
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clear", err, 0);
    A_t = 4'b0010; A_f = 4'b0010;
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    repeat (2) @(negedge clk);
    chk("err_set_wins", err, 1);
    err_clr = 1'b0;
    drive_null();
    repeat (3) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clear2", err, 0);

    // Read-before-write: load lands on the S_READ edge for the same address
    issue(4'd5, 4'h6);
    repeat (3) @(negedge clk);
    load_en = 1'b1; load_addr = 4'd5; load_data = 4'h3;
    @(negedge clk);
    load_en = 1'b0;
    wait_ko(1'b0, "ko_fall_rbw");
    // Address swap to another DATA pattern while holding DATA is ignored
    drive_addr(4'd3);
    repeat (5) @(negedge clk);
    chk("hold_d_t", D_t, 4'h6);
    chk("hold_ko", Ko, 0);
    chk("hold_err", err, 0);
    finish_txn();
    issue(4'd5, 4'h3);
    wait_ko(1'b0, "ko_fall_new_word");
    finish_txn();

    // Async reset while DATA 0xF is presented
    issue(4'd9, 4'hF);
    wait_ko(1'b0, "ko_fall_a9");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ko", Ko, 1);
    chk("async_rst_d", {D_t, D_f}, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{4'h0, cyc + LAT});
    wait_ko(1'b0, "ko_fall_after_rst");
    finish_txn();
    issue(4'd3, 4'h0);
    wait_ko(1'b0, "ko_fall_cleared_mem");
    finish_txn();

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dual_rail_mem_responder.md
Name: dual_rail_mem_responder

Overview:
- Responder side of the dual-rail (t/f) memory address interface; receives the address wavefront driven by the address mux stage.
- Synchronizes the address rails into the clock domain and detects complete DATA, complete NULL and illegal codes.
- Reads a small register-file memory and returns the word as a dual-rail data wavefront under a four-phase NULL/DATA handshake (Ko out, Ki in).
- Includes a synchronous single-rail load port for memory initialization.

Parameters:
- AW, 4, address width in bits (memory depth = 2^AW words).
- DW, 4, data word width in bits.
- SYNC_STAGES, 2, flop stages on every incoming rail and on Ki (allowed values 2..3).

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- A_t  input  AW  address true rails; bit i pairs with A_f[i].
- A_f  input  AW  address false rails.
- Ki  input  1  consumer acknowledge: 1 = request DATA, 0 = request NULL.
- Ko  output  1  completion/acknowledge to address source: 1 = ready for DATA, 0 = DATA consumed, send NULL.
- D_t  output  DW  data true rails.
- D_f  output  DW  data false rails.
- load_en  input  1  synchronous write strobe.
- load_addr  input  AW  write address.
- load_data  input  DW  write data.
- err  output  1  sticky illegal-code flag.
- err_clr  input  1  synchronous clear of err.

Behaviour:
- Reset (async, rst=1):
  - state=S_WAIT_DATA, Ko=1, D_t=D_f=0 (NULL), err=0.
  - All memory words = 0; synchronizer flops = 0; latched address = 0.
- Synchronizers: A_t, A_f and Ki each pass through SYNC_STAGES flops. All decode uses the synchronized copies (sA_t, sA_f, sKi).
- Per-bit classification, from (sA_t[i], sA_f[i]):
  - 10 or 01 = DATA, 00 = NULL, 11 = illegal.
  - Complete DATA: every bit is DATA. Complete NULL: every bit is NULL.
  - Any other mix with no 11 is partial and is ignored (keep waiting).
- Illegal code: if any bit is 11 in any cycle, err <= 1 the next edge. The state machine does not advance on that cycle.
- err clearing: err_clr clears err; err_clr=1 together with a new illegal code leaves err=1 (set wins).
- State machine (outputs registered):
  - S_WAIT_DATA:
    - Outputs: Ko=1, D NULL.
    - Complete DATA and sKi=1 and no illegal bit: latch address (bit i = sA_t[i]) and go to S_READ.
  - S_READ:
    - Load data register from mem[latched address]; go to S_DATA. Lasts exactly one cycle.
  - S_DATA:
    - Outputs: D_t = data register, D_f = ~data register, Ko=0.
    - Complete NULL and sKi=0: go to S_NULL.
  - S_NULL:
    - Outputs: D NULL, Ko=1.
    - sKi=1: go to S_WAIT_DATA.
- Latency: complete DATA at the pins to DATA on D is SYNC_STAGES+2 clk edges. That is one edge to decode/latch, one edge in S_READ, and the registered output update.
- Ko timing: Ko falls on the same edge that D becomes DATA.
- D never shows a partial word: all DW bit pairs change on one edge, and never show 11.
- Load port:
  - load_en=1 writes mem[load_addr] <= load_data at the edge, in any state.
  - Write and S_READ to the same address in the same cycle: the read returns the old word (read-before-write).
- Address changes while in S_DATA:
  - A change to a different DATA pattern without a NULL in between is ignored. D holds, and no err is raised unless an 11 code appears.
- Reset mid-operation: rst asserted in any state forces the reset values immediately, without waiting for a clock. After release, the first complete DATA plus sKi=1 starts a new cycle.

Test Plan:
- Reset, load 0xA at addr 3, then drive A=3 as DATA (A_t=0011, A_f=1100) with Ki=1 -> after SYNC_STAGES+2 edges D_t=1010, D_f=0101, Ko=0.
- From the previous case, drive A NULL with Ki=0, then Ki=1 -> D=NULL, Ko=1 one edge after sKi=0; S_WAIT_DATA resumes.
- Partial address (bit 2 NULL, others DATA) held 10 cycles -> Ko stays 1, D NULL, err=0. Then complete bit 2 -> read proceeds normally.
- Force A_t[1]=A_f[1]=1 -> err=1, and Ko and D are unchanged. err_clr pulse -> err=0. err_clr coincident with 11 still present -> err stays 1.
- load_en to addr 5 with 0x3 on the same edge S_READ reads addr 5 (old value 0x6) -> D shows 0x6. The next transaction to addr 5 returns 0x3.
- rst asserted while in S_DATA with D=0xF -> D_t=D_f=0 and Ko=1 without a clock edge. All memory reads then return 0.
